csa_add_arbiter: RTL

Round-robin arbiter that shares one `carry_save_adder_pipeline` instance among `NREQ` requesters. Each requester offers an operand pair with a valid/ready handshake. The arbiter issues at most one pair per cycle into the adder, tags it with the requester ID through a shift register matched to the adder latency, and queues each result in a response FIFO. Issue is credit-limited because the adder pipeline cannot stall, so no result is ever dropped.

---
 rtl/csa_add_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/csa_add_arbiter.sv
// Round-robin, credit-limited front end sharing one carry-save adder pipeline.
// Optional per-requester grant counters when CSA_ARB_STATS_EN is defined.
module csa_add_arbiter #(
    parameter int N     = 32,
    parameter int NREQ  = 4,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic [N-1:0]              add_a,
    output logic [N-1:0]              add_b,
    input  logic [N-1:0]              add_sum,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]              rsp_sum
`ifdef CSA_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]        grant_cnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Stage 0 lines up with add_a; the last stage lines up with add_sum.
    localparam int TS = LAT + 1;
    localparam int FW = $clog2(TS + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  gnt;
    logic           any_req;
    logic           issue_ok;
    logic           xfer;
    int             idx;

    logic [TS-1:0]  tag_vld;
    logic [IW-1:0]  tag_id [TS];
    logic [FW-1:0]  inflight;

    logic [IW-1:0]  mem_id  [DEPTH];
    logic [N-1:0]   mem_sum [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [IW-1:0]  hold_id;
    logic [N-1:0]   hold_sum;
    logic           push;
    logic           pop;

    always_comb begin
        gnt     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req && req_valid[IW'(idx)]) begin
                any_req = 1'b1;
                gnt     = IW'(idx);
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int s = 0; s < TS; s++) begin
            inflight = inflight + FW'(tag_vld[s]);
        end
    end

    // A pop this cycle frees its credit only from the next cycle on.
    assign issue_ok = (32'(count) + 32'(inflight)) < 32'(DEPTH);

    always_comb begin
        req_ready = '0;
        if (reset && issue_ok && any_req) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign xfer = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_a  <= '0;
            add_b  <= '0;
            rr_ptr <= '0;
        end else if (xfer) begin
            add_a  <= req_a[int'(gnt)*N +: N];
            add_b  <= req_b[int'(gnt)*N +: N];
            if (int'(gnt) == NREQ - 1) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= gnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
            for (int s = 0; s < TS; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_vld[0] <= xfer;
            tag_id[0]  <= gnt;
            for (int s = 1; s < TS; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    assign push      = tag_vld[TS-1];
    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]  <= tag_id[TS-1];
            mem_sum[wr_ptr] <= add_sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Remember the last head so the outputs stay stable once drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_id  <= '0;
            hold_sum <= '0;
        end else if (pop) begin
            hold_id  <= mem_id[rd_ptr];
            hold_sum <= mem_sum[rd_ptr];
        end
    end

    assign rsp_id  = rsp_valid ? mem_id[rd_ptr]  : hold_id;
    assign rsp_sum = rsp_valid ? mem_sum[rd_ptr] : hold_sum;

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(push && !pop && count == FULL)
    );

`ifdef CSA_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
        end else if (xfer) begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt == IW'(i)) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
